// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux: grants one requester for hold+1 cycles.
// Optional grant extension via the lock input when MUX_SEL_ARB_LOCK_EN is defined.
module mux_sel_arbiter #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [HOLD_W-1:0] hold,
    output logic              s1,
    output logic              s2,
    output logic [3:0]        gnt,
    output logic              valid,
    output logic              done
`ifdef MUX_SEL_ARB_LOCK_EN
    ,
    input  logic              lock
`endif
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          cur_q, cur_d;
    logic [1:0]          sel_q, sel_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [3:0]          gnt_q, gnt_d;
    logic                valid_q, valid_d;
    logic                lock_w;
    logic [1:0]          base;
    logic [1:0]          win;

`ifdef MUX_SEL_ARB_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    // Scan downward so the closest set bit to base is the last one assigned.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] b);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = b;
        for (int i = 3; i >= 0; i--) begin
            idx = b + 2'(i);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    // At the end of a grant, arbitration must already see the advanced pointer.
    assign base = (state_q == GRANT) ? (cur_q + 2'd1) : ptr_q;
    assign win  = rr_pick(req, base);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    cur_d   = win;
                    sel_d   = win;
                    cnt_d   = hold;
                    gnt_d   = 4'b0001 << win;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end else if (lock_w) begin
                    cnt_d = hold;
                end else begin
                    ptr_d = cur_q + 2'd1;
                    if (|req) begin
                        cur_d = win;
                        sel_d = win;
                        cnt_d = hold;
                        gnt_d = 4'b0001 << win;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cur_q   <= 2'd0;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign s1    = sel_q[1];
    assign s2    = sel_q[0];
    assign gnt   = gnt_q;
    assign valid = valid_q;
    assign done  = valid_q & (cnt_q == '0) & ~lock_w;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed self-checking bench for mux_sel_arbiter; lock scenario runs only with MUX_SEL_ARB_LOCK_EN.
module tb_mux_sel_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] hold;
    logic       s1;
    logic       s2;
    logic [3:0] gnt;
    logic       valid;
    logic       done;
`ifdef MUX_SEL_ARB_LOCK_EN
    logic       lock;
`endif

    int n_checks;
    int n_errors;

    mux_sel_arbiter #(.HOLD_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .hold  (hold),
        .s1    (s1),
        .s2    (s2),
        .gnt   (gnt),
        .valid (valid),
        .done  (done)
`ifdef MUX_SEL_ARB_LOCK_EN
        ,
        .lock  (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic exp_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic v, input logic d);
        check({tag, ".gnt"},   32'(gnt), 32'(g));
        check({tag, ".sel"},   32'({s1, s2}), 32'(s));
        check({tag, ".valid"}, 32'(valid), 32'(v));
        check({tag, ".done"},  32'(done), 32'(d));
    endtask

    // Advance one clock and settle just past the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rot_seq [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        req  = 4'b0000;
        hold = 4'd0;
`ifdef MUX_SEL_ARB_LOCK_EN
        lock = 1'b0;
`endif
        rot_seq[0] = 2'd0; rot_seq[1] = 2'd1; rot_seq[2] = 2'd2;
        rot_seq[3] = 2'd3; rot_seq[4] = 2'd0;

        cyc();
        cyc();
        exp_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc();
        exp_out("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Rotation with single-cycle grants
        req  = 4'b1111;
        hold = 4'd0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            exp_out($sformatf("rot%0d", i), 4'b0001 << rot_seq[i], rot_seq[i], 1'b1, 1'b1);
        end

        // Hold length 4 on ch1; request drops during the grant
        req  = 4'b0010;
        hold = 4'd3;
        cyc();
        exp_out("hold_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        cyc();
        exp_out("hold_c2", 4'b0010, 2'd1, 1'b1, 1'b0);
        cyc();
        exp_out("hold_c3", 4'b0010, 2'd1, 1'b1, 1'b0);
        cyc();
        exp_out("hold_c4", 4'b0010, 2'd1, 1'b1, 1'b1);
        cyc();
        exp_out("idle_keepsel", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Serve ch2 so the pointer lands on 3, then wrap 3 -> 0
        req  = 4'b0100;
        hold = 4'd0;
        cyc();
        exp_out("wrap_c2", 4'b0100, 2'd2, 1'b1, 1'b1);
        req = 4'b1001;
        cyc();
        exp_out("wrap_c3", 4'b1000, 2'd3, 1'b1, 1'b1);
        cyc();
        exp_out("wrap_c0", 4'b0001, 2'd0, 1'b1, 1'b1);
        req = 4'b0001;
        cyc();
        exp_out("solo_a", 4'b0001, 2'd0, 1'b1, 1'b1);
        cyc();
        exp_out("solo_b", 4'b0001, 2'd0, 1'b1, 1'b1);

        // Maximum hold: 16-cycle grant, hold change mid-grant ignored
        hold = 4'hF;
        cyc();
        exp_out("max_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        hold = 4'd0;
        for (int i = 2; i <= 15; i++) begin
            cyc();
            check($sformatf("max_c%0d.done", i), 32'(done), 32'd0);
        end
        cyc();
        exp_out("max_c16", 4'b0001, 2'd0, 1'b1, 1'b1);
        req = 4'b0000;
        cyc();
        exp_out("max_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-grant, then first grant from ptr=0
        req  = 4'b0010;
        hold = 4'd3;
        cyc();
        exp_out("pre_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        exp_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        cyc();
        rst  = 1'b0;
        req  = 4'b0100;
        hold = 4'd0;
        cyc();
        exp_out("post_rst", 4'b0100, 2'd2, 1'b1, 1'b1);
        req = 4'b0000;
        cyc();
        exp_out("post_rst_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

`ifdef MUX_SEL_ARB_LOCK_EN
        // ptr is 3 here, so ch0 wins first; lock extends it to 4 cycles
        req  = 4'b0011;
        hold = 4'd1;
        cyc();
        exp_out("lock_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc();
        lock = 1'b1;
        #1;
        exp_out("lock_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc();
        lock = 1'b0;
        #1;
        exp_out("lock_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc();
        exp_out("lock_c4", 4'b0001, 2'd0, 1'b1, 1'b1);
        cyc();
        exp_out("lock_next", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        cyc();
        cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
